// File: rtl/frame_streamer.sv
// frame_streamer: WIDTH x HEIGHT frame memory loaded through a write port
// and streamed out one pixel per clock in raster order when start is seen.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset (frame memory is kept)
//   wr_en     in   frame-memory write strobe (accepted only in IDLE)
//   wr_addr   in   10-bit raster address, row*WIDTH+col
//   wr_data   in   pixel to store
//   start     in   begin streaming the stored frame (IDLE only)
//   data_out  out  registered streamed pixel, holds when not valid
//   valid_out out  data_out carries a frame pixel this cycle
//   busy      out  high while streaming
//   done      out  one-cycle pulse after the last pixel
//   wr_drop   out  sticky: a write was discarded

module frame_streamer #(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [9:0]           wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_drop
);

    localparam int DEPTH = WIDTH * HEIGHT;

    localparam logic [10:0] DEPTH_L  = 11'(DEPTH);
    localparam logic [4:0]  COL_LAST = 5'(WIDTH - 1);
    localparam logic [9:0]  WIDTH_L  = 10'(WIDTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;

    logic [DATA_BITS-1:0] mem [0:DEPTH-1];

    logic [9:0] pix_cnt;
    logic [4:0] col_idx;
    logic [4:0] row_idx;
    logic [9:0] rd_addr;

    logic in_range;
    logic wr_ok;
    logic wr_bad;
    logic all_read;

    assign in_range = ({1'b0, wr_addr} < DEPTH_L);

    // Writes are legal only while idle and inside the frame.
    assign wr_ok  = wr_en && (state == IDLE) && in_range;
    assign wr_bad = wr_en && !wr_ok;

    // pix_cnt counts pixels already emitted; reaching DEPTH means the
    // frame is finished and this cycle only moves to DONE.
    assign all_read = ({1'b0, pix_cnt} == DEPTH_L);

    assign rd_addr = ({5'd0, row_idx} * WIDTH_L) + {5'd0, col_idx};

    assign busy = (state == STREAM);
    assign done = (state == DONE);

    // No reset on the memory: frame contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            wr_drop   <= 1'b0;
        end else begin
            // A discarded write wins over the clear-on-start.
            if (wr_bad) begin
                wr_drop <= 1'b1;
            end else if ((state == IDLE) && start) begin
                wr_drop <= 1'b0;
            end

            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (start) begin
                        state   <= STREAM;
                        pix_cnt <= '0;
                        col_idx <= '0;
                        row_idx <= '0;
                    end
                end
                STREAM: begin
                    if (all_read) begin
                        state     <= DONE;
                        valid_out <= 1'b0;
                    end else begin
                        data_out  <= mem[rd_addr];
                        valid_out <= 1'b1;
                        pix_cnt   <= pix_cnt + 10'd1;
                        if (col_idx == COL_LAST) begin
                            col_idx <= '0;
                            row_idx <= row_idx + 5'd1;
                        end else begin
                            col_idx <= col_idx + 5'd1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed/randomized bench for frame_streamer with a
// behavioural frame model and expected-stream checking.

module tb_frame_streamer;

    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [7:0] data_out;
    logic       valid_out;
    logic       busy;
    logic       done;
    logic       wr_drop;

    int checks;
    int failures;

    logic [7:0] ref_mem [N];
    logic       exp_drop;
    logic [7:0] exp_last;

    frame_streamer #(
        .WIDTH(W),
        .HEIGHT(H),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .data_out(data_out),
        .valid_out(valid_out),
        .busy(busy),
        .done(done),
        .wr_drop(wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 10'(addr);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (addr < N) ref_mem[addr] = d;
        else exp_drop = 1'b1;
        chk("wr_drop_after_write", 32'(wr_drop), 32'(exp_drop));
    endtask

    // Streams one frame and checks every cycle against ref_mem.
    // restart_at / wr_at / rst_at: pixel index (1..N) at which to inject
    // a stray start, a discarded write, or a reset; 0 disables.
    task automatic stream_frame(input int restart_at, input int wr_at,
                                input int rst_at, input bit same_wr);
        int vcount;
        vcount = 0;
        start = 1'b1;
        if (same_wr) begin
            wr_en   = 1'b1;
            wr_addr = 10'd0;
            wr_data = 8'h55;
            ref_mem[0] = 8'h55;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        exp_drop = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(valid_out), 32'd0);
        chk("start_drop_clr", 32'(wr_drop), 32'(exp_drop));
        for (int k = 1; k <= N; k++) begin
            if (k == restart_at) start = 1'b1;
            if (k == rst_at) rst_n = 1'b0;
            if (k == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = 10'd5;
                wr_data = 8'h77;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
            if (k == rst_at) begin
                chk("rst_valid", 32'(valid_out), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_data", 32'(data_out), 32'd0);
                chk("rst_drop", 32'(wr_drop), 32'd0);
                rst_n = 1'b1;
                exp_drop = 1'b0;
                tick();
                chk("post_rst_done", 32'(done), 32'd0);
                chk("post_rst_busy", 32'(busy), 32'd0);
                return;
            end
            if (valid_out === 1'b1) vcount++;
            if (k == wr_at) exp_drop = 1'b1;
            chk("pix_valid", 32'(valid_out), 32'd1);
            chk("pix_data", 32'(data_out), 32'(ref_mem[k-1]));
            chk("pix_busy", 32'(busy), 32'd1);
            chk("pix_done", 32'(done), 32'd0);
            chk("pix_drop", 32'(wr_drop), 32'(exp_drop));
        end
        exp_last = ref_mem[N-1];
        tick();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid", 32'(valid_out), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_hold", 32'(data_out), 32'(exp_last));
        chk("valid_count", 32'(vcount), 32'(N));
        if (restart_at > 0) start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(valid_out), 32'd0);
        chk("idle_hold", 32'(data_out), 32'(exp_last));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_drop = 1'b0;
        exp_last = 8'h00;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;

        tick();
        tick();
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_valid", 32'(valid_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_drop", 32'(wr_drop), 32'd0);
        rst_n = 1'b1;
        tick();

        // Ramp pattern i mod 256.
        for (int i = 0; i < N; i++) do_write(i, 8'(i % 256));
        stream_frame(0, 0, 0, 1'b0);

        // Write + start on the same edge: new value streams first.
        do_write(0, 8'hAA);
        stream_frame(0, 0, 0, 1'b1);
        chk("same_edge_pix0", 32'(ref_mem[0]), 32'h55);

        // Random frame, out-of-range write, write during stream.
        for (int i = 0; i < N; i++) do_write(i, 8'($urandom));
        do_write(900, 8'h12);
        chk("oor_drop", 32'(wr_drop), 32'd1);
        stream_frame(0, 5, 0, 1'b0);
        chk("stream_wr_drop", 32'(wr_drop), 32'd1);

        // Stray starts mid-frame and in DONE are ignored.
        stream_frame(400, 0, 0, 1'b0);

        // Random addresses, then abort at pixel 300 and restream.
        for (int i = 0; i < 64; i++)
            do_write($urandom_range(N - 1), 8'($urandom));
        stream_frame(0, 0, 300, 1'b0);
        stream_frame(0, 0, 0, 1'b0);

        // Back-to-back frames from the first IDLE cycle.
        stream_frame(0, 0, 0, 1'b0);
        stream_frame(0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter WIDTH, default 28, pixels per image row.
REQ-002 Parameter HEIGHT, default 28, rows per image.
REQ-003 Parameter DATA_BITS, default 8, pixel width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 wr_en  input  1  frame-memory write strobe.
REQ-007 wr_addr  input  10  raster pixel address, row*WIDTH+col.
REQ-008 wr_data  input  DATA_BITS  pixel to store.
REQ-009 start  input  1  request to stream the stored frame.
REQ-010 data_out  output  DATA_BITS  streamed pixel, registered.
REQ-011 valid_out  output  1  data_out holds a frame pixel.
REQ-012 busy  output  1  high in STREAM state.
REQ-013 done  output  1  one-cycle pulse after the last pixel.
REQ-014 wr_drop  output  1  sticky flag: a write was discarded.

Function
REQ-015 Block SHALL hold a WIDTH*HEIGHT x DATA_BITS frame memory, write-only from the wr_* port and read-only by the streamer.
REQ-016 FSM SHALL have exactly three states: IDLE, STREAM, DONE.
REQ-017 In IDLE, wr_en with wr_addr < WIDTH*HEIGHT SHALL store wr_data at wr_addr on that edge.
REQ-018 A write with wr_addr >= WIDTH*HEIGHT, or any write outside IDLE, SHALL be discarded and SHALL set wr_drop on the same edge.
REQ-019 IDLE -> STREAM on the edge where start=1; pixel counter, col_idx and row_idx SHALL be cleared to 0 on that edge; wr_drop SHALL be cleared on that edge unless the same-edge write is itself discarded.
REQ-020 If wr_en and start are both high on the same edge in IDLE, the write SHALL commit, and the streamed frame SHALL contain the new value.
REQ-021 First pixel: when start is sampled at edge N, edge N+1 SHALL register data_out=mem[0] and valid_out=1.
REQ-022 In STREAM, one pixel SHALL be emitted per edge in raster order (col increments; at col=WIDTH-1, col wraps to 0 and row increments), with no gaps.
REQ-023 Exactly WIDTH*HEIGHT pixels SHALL be emitted: the last pixel, mem[WIDTH*HEIGHT-1], is registered at edge N+WIDTH*HEIGHT.
REQ-024 STREAM -> DONE after the last read; at edge N+WIDTH*HEIGHT+1, valid_out=0 and done=1.
REQ-025 DONE -> IDLE unconditionally on the next edge, with done=0; done SHALL never exceed one cycle.
REQ-026 start while in STREAM or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-027 busy SHALL equal (state==STREAM): high from edge N through edge N+WIDTH*HEIGHT inclusive.
REQ-028 When valid_out=0, data_out SHALL hold its last value.
REQ-029 Pixel counter SHALL be 10 bits wide; col_idx and row_idx SHALL be 5 bits wide; none may wrap within a frame.

Reset
REQ-030 With rst_n=0 at an edge, state=IDLE and all counters=0 on that edge.
REQ-031 With rst_n=0 at an edge, data_out, valid_out, busy, done and wr_drop SHALL all be 0 on that edge.
REQ-032 Reset SHALL NOT clear the frame memory; contents SHALL persist across reset.
REQ-033 Reset asserted mid-STREAM SHALL abort the frame immediately, with no done pulse.
REQ-034 After a mid-STREAM reset, a new start SHALL restream from pixel 0.

Verification
REQ-035 Write mem[i]=i mod 256 for i=0..783, pulse start at edge N -> valid_out=1 for exactly 784 consecutive cycles starting at edge N+1, data_out=0,1,...,255,0,...,15 (783 mod 256 = 15), done=1 only at edge N+785.
REQ-036 Write addr 0=0xAA; next cycle assert wr_en (addr 0, data 0x55) and start together -> first streamed pixel = 0x55, wr_drop=0.
REQ-037 During STREAM write addr 5=0x77; also write addr 900 in IDLE -> wr_drop=1 in both cases, frame content unchanged; next start clears wr_drop.
REQ-038 Pulse start again at pixel 400 and during DONE -> no restart, total valid count 784, single done pulse.
REQ-039 Assert rst_n=0 at pixel 300 -> valid_out, busy, done, data_out all 0 on that edge, no done pulse; after release, start -> pixel 0 equals the pre-reset mem[0].
REQ-040 Connect data_out to conv1_buf data_in and drive two back-to-back frames (start at the first IDLE cycle) -> conv1_buf emits a 5x5 window at (row 0, col 0) equal to mem rows 0-4, cols 0-4.
